// File: rtl/mod10_pkg.sv
// Shared types for the mod-10 count stream monitor and its step classifier.
package mod10_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    STEP_UP   = 3'd0,
    STEP_DOWN = 3'd1,
    STEP_HOLD = 3'd2,
    STEP_JUMP = 3'd3,
    STEP_BAD  = 3'd4
  } step_t;

  localparam logic [3:0] MOD10_MAX = 4'd9;

endpackage

// File: rtl/mod10_seq_monitor_if.sv
// Sample stream in, lock/direction/error status out.
interface mod10_seq_monitor_if #(parameter int CNT_W = 8);
  logic [3:0]       din;
  logic             din_valid;
  logic             err_clr;
  logic             locked;
  logic             dir;
  logic             step_ok;
  logic             rev;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport master (output din, din_valid, err_clr,
                  input  locked, dir, step_ok, rev, err, err_cnt);
  modport slave  (input  din, din_valid, err_clr,
                  output locked, dir, step_ok, rev, err, err_cnt);
endinterface

// File: rtl/mod10_step_classify.sv
// Classifies sample s against previous legal sample p; without a reference only BAD is meaningful.
module mod10_step_classify
  import mod10_pkg::*;
(
  input  logic [3:0] p,
  input  logic       p_valid,
  input  logic [3:0] s,
  output step_t      step
);
  logic [3:0] p_up, p_dn;

  always_comb begin
    p_up = (p == MOD10_MAX) ? 4'd0 : p + 4'd1;
    p_dn = (p == 4'd0) ? MOD10_MAX : p - 4'd1;
    step = STEP_JUMP;
    if (s > MOD10_MAX)  step = STEP_BAD;
    else if (!p_valid)  step = STEP_JUMP;
    else if (s == p_up) step = STEP_UP;
    else if (s == p_dn) step = STEP_DOWN;
    else if (s == p)    step = STEP_HOLD;
  end
endmodule

// File: rtl/mod10_seq_monitor.sv
// Direction decoder / protocol checker for a free-running mod-10 up/down count stream.
module mod10_seq_monitor
  import mod10_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int CNT_W      = 8
)(
  input  logic clk,
  input  logic rst,
  mod10_seq_monitor_if.slave bus
);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int CERR_W = $clog2(ERR_LIMIT + 1);

  state_t           state_q, state_n;
  step_t            step;
  logic [3:0]       p_q, p_n;
  logic             pv_q, pv_n;
  logic [RUN_W-1:0] run_q, run_n;
  logic [CERR_W-1:0] cerr_q, cerr_n;
  logic             cand_q, cand_n, locked_q, locked_n, dir_q, dir_n;
  logic             step_ok_q, step_ok_n, rev_q, rev_n, err_q, err_n;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_n;
  logic             is_up;

  mod10_step_classify u_cls (.p(p_q), .p_valid(pv_q), .s(bus.din), .step(step));

  assign is_up = (step == STEP_UP);

  always_comb begin
    state_n   = state_q;
    p_n       = p_q;
    pv_n      = pv_q;
    run_n     = run_q;
    cerr_n    = cerr_q;
    cand_n    = cand_q;
    locked_n  = locked_q;
    dir_n     = dir_q;
    step_ok_n = 1'b0;
    rev_n     = 1'b0;
    err_n     = 1'b0;
    if (bus.din_valid) begin
      if (step == STEP_BAD) pv_n = 1'b0;
      else begin
        p_n  = bus.din;
        pv_n = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (step == STEP_BAD) err_n = 1'b1;
          else begin
            state_n = ST_ACQ;
            run_n   = '0;
          end
        end
        ST_ACQ: begin
          case (step)
            STEP_UP, STEP_DOWN: begin
              step_ok_n = 1'b1;
              // A fresh run (run==0) adopts whatever direction this step shows.
              if (run_q != '0 && is_up == cand_q) run_n = run_q + 1'b1;
              else begin
                cand_n = is_up;
                run_n  = RUN_W'(1);
              end
              if (run_n == RUN_W'(LOCK_COUNT)) begin
                state_n  = ST_LOCK;
                locked_n = 1'b1;
                dir_n    = cand_n;
                cerr_n   = '0;
              end
            end
            STEP_JUMP: run_n = '0;
            STEP_BAD: begin
              err_n   = 1'b1;
              state_n = ST_IDLE;
              run_n   = '0;
            end
            default: ;
          endcase
        end
        ST_LOCK: begin
          case (step)
            STEP_UP, STEP_DOWN: begin
              step_ok_n = 1'b1;
              cerr_n    = '0;
              if (is_up != dir_q) begin
                dir_n = is_up;
                rev_n = 1'b1;
              end
            end
            STEP_BAD: begin
              err_n    = 1'b1;
              state_n  = ST_IDLE;
              locked_n = 1'b0;
              cerr_n   = '0;
              run_n    = '0;
            end
            default: begin
              err_n = 1'b1;
              if (cerr_q + 1'b1 == CERR_W'(ERR_LIMIT)) begin
                state_n  = ST_ACQ;
                run_n    = '0;
                locked_n = 1'b0;
                cerr_n   = '0;
              end else begin
                cerr_n = cerr_q + 1'b1;
              end
            end
          endcase
        end
        default: state_n = ST_IDLE;
      endcase
    end
    // A clear coinciding with a new error leaves that error counted.
    err_cnt_n = err_cnt_q;
    if (bus.err_clr)                    err_cnt_n = err_n ? CNT_W'(1) : '0;
    else if (err_n && err_cnt_q != '1)  err_cnt_n = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      p_q       <= '0;
      pv_q      <= 1'b0;
      run_q     <= '0;
      cerr_q    <= '0;
      cand_q    <= 1'b1;
      locked_q  <= 1'b0;
      dir_q     <= 1'b1;
      step_ok_q <= 1'b0;
      rev_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      p_q       <= p_n;
      pv_q      <= pv_n;
      run_q     <= run_n;
      cerr_q    <= cerr_n;
      cand_q    <= cand_n;
      locked_q  <= locked_n;
      dir_q     <= dir_n;
      step_ok_q <= step_ok_n;
      rev_q     <= rev_n;
      err_q     <= err_n;
      err_cnt_q <= err_cnt_n;
    end
  end

  assign bus.locked  = locked_q;
  assign bus.dir     = dir_q;
  assign bus.step_ok = step_ok_q;
  assign bus.rev     = rev_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
endmodule
